// File: rtl/rob_queue.sv
`default_nettype none
// ============================================================================
//  Module   : rob_queue
//  Purpose  : Parametrised reorder buffer. Allocates entries in program order,
//             captures results from CDB_COUNT result buses per cycle, retires
//             the oldest finished entry and flushes all younger state when a
//             taken jump retires.
//  Ports    : clk/reset          clock, synchronous active-high reset
//             alloc_*            dispatch-side allocation handshake + fields
//             cdb_*              per-bus result strobes, tags, data, redirects
//             commit_*           head-entry retire handshake + fields
//             flush/flush_addr   one-cycle redirect pulse + target
//             count              occupied entries
//  Revision : 1.0  initial release
// ============================================================================
module rob_queue #(
  parameter int DEPTH     = 16,
  parameter int XLEN      = 32,
  parameter int ARN_W     = 5,
  parameter int RRN_W     = 6,
  parameter int CDB_COUNT = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [XLEN-1:0]            alloc_address,
  input  logic [ARN_W-1:0]           alloc_arn,
  input  logic [RRN_W-1:0]           alloc_rrn,
  input  logic                       alloc_ignore,
  input  logic [CDB_COUNT-1:0]       cdb_valid,
  input  logic [CDB_COUNT*RRN_W-1:0] cdb_rrn,
  input  logic [CDB_COUNT*XLEN-1:0]  cdb_data,
  input  logic [CDB_COUNT-1:0]       cdb_jump,
  input  logic [CDB_COUNT*XLEN-1:0]  cdb_jump_address,
  output logic                       commit_valid,
  input  logic                       commit_ready,
  output logic                       commit_write,
  output logic [XLEN-1:0]            commit_data,
  output logic [XLEN-1:0]            commit_address,
  output logic [ARN_W-1:0]           commit_arn,
  output logic [RRN_W-1:0]           commit_rrn,
  output logic                       flush,
  output logic [XLEN-1:0]            flush_address,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;

  logic [DEPTH-1:0] valid_q,    valid_d;
  logic [DEPTH-1:0] finished_q, finished_d;
  logic [DEPTH-1:0] jump_q,     jump_d;
  logic [DEPTH-1:0] ignore_q,   ignore_d;
  logic [XLEN-1:0]  data_q      [DEPTH];
  logic [XLEN-1:0]  data_d      [DEPTH];
  logic [XLEN-1:0]  address_q   [DEPTH];
  logic [XLEN-1:0]  address_d   [DEPTH];
  logic [XLEN-1:0]  jaddr_q     [DEPTH];
  logic [XLEN-1:0]  jaddr_d     [DEPTH];
  logic [ARN_W-1:0] arn_q       [DEPTH];
  logic [ARN_W-1:0] arn_d       [DEPTH];
  logic [RRN_W-1:0] rrn_q       [DEPTH];
  logic [RRN_W-1:0] rrn_d       [DEPTH];

  logic             flush_q, flush_d;
  logic [XLEN-1:0]  flush_address_q, flush_address_d;

  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  logic             empty;
  logic             full;
  logic             do_alloc;
  logic             do_retire;

  assign head_idx  = head_q[IDX_W-1:0];
  assign tail_idx  = tail_q[IDX_W-1:0];
  assign empty     = (head_q == tail_q);
  assign full      = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);

  // Handshake signals depend only on registered state (plus reset).
  assign alloc_ready  = !reset && !full && !flush_q;
  assign commit_valid = !reset && !empty && finished_q[head_idx];
  assign do_alloc     = alloc_valid && alloc_ready;
  assign do_retire    = commit_valid && commit_ready;

  assign commit_write   = commit_valid && (arn_q[head_idx] != '0) && !ignore_q[head_idx];
  assign commit_data    = data_q[head_idx];
  assign commit_address = address_q[head_idx];
  assign commit_arn     = arn_q[head_idx];
  assign commit_rrn     = rrn_q[head_idx];
  assign flush          = flush_q;
  assign flush_address  = flush_address_q;
  assign count          = tail_q - head_q;

  always_comb begin
    head_d          = head_q;
    tail_d          = tail_q;
    valid_d         = valid_q;
    finished_d      = finished_q;
    jump_d          = jump_q;
    ignore_d        = ignore_q;
    data_d          = data_q;
    address_d       = address_q;
    jaddr_d         = jaddr_q;
    arn_d           = arn_q;
    rrn_d           = rrn_q;
    flush_d         = 1'b0;
    flush_address_d = flush_address_q;

    // Result capture. Buses are scanned from highest to lowest index so the
    // lowest-indexed matching bus is the last writer and therefore wins.
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !finished_q[i]) begin
        for (int b = CDB_COUNT - 1; b >= 0; b--) begin
          if (cdb_valid[b] && (rrn_q[i] == cdb_rrn[b*RRN_W +: RRN_W])) begin
            finished_d[i] = 1'b1;
            data_d[i]     = cdb_data[b*XLEN +: XLEN];
            jump_d[i]     = cdb_jump[b];
            jaddr_d[i]    = cdb_jump_address[b*XLEN +: XLEN];
          end
        end
      end
    end

    if (do_retire) begin
      valid_d[head_idx] = 1'b0;
      head_d            = head_q + PTR_ONE;
    end

    // The tail slot was invalid last cycle, so it cannot have captured a
    // result above; allocation simply overwrites it.
    if (do_alloc) begin
      valid_d[tail_idx]    = 1'b1;
      finished_d[tail_idx] = alloc_ignore;
      jump_d[tail_idx]     = 1'b0;
      ignore_d[tail_idx]   = alloc_ignore;
      data_d[tail_idx]     = '0;
      address_d[tail_idx]  = alloc_address;
      jaddr_d[tail_idx]    = '0;
      arn_d[tail_idx]      = alloc_arn;
      rrn_d[tail_idx]      = alloc_rrn;
      tail_d               = tail_q + PTR_ONE;
    end

    // A retiring taken jump discards everything younger, including any
    // allocation accepted in the same cycle.
    if (do_retire && jump_q[head_idx]) begin
      valid_d         = '0;
      head_d          = '0;
      tail_d          = '0;
      flush_d         = 1'b1;
      flush_address_d = jaddr_q[head_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q          <= '0;
      tail_q          <= '0;
      valid_q         <= '0;
      finished_q      <= '0;
      jump_q          <= '0;
      ignore_q        <= '0;
      flush_q         <= 1'b0;
      flush_address_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]    <= '0;
        address_q[i] <= '0;
        jaddr_q[i]   <= '0;
        arn_q[i]     <= '0;
        rrn_q[i]     <= '0;
      end
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      valid_q         <= valid_d;
      finished_q      <= finished_d;
      jump_q          <= jump_d;
      ignore_q        <= ignore_d;
      flush_q         <= flush_d;
      flush_address_q <= flush_address_d;
      data_q          <= data_d;
      address_q       <= address_d;
      jaddr_q         <= jaddr_d;
      arn_q           <= arn_d;
      rrn_q           <= rrn_d;
    end
  end

endmodule
`default_nettype wire
